sha256_ctrl: RTL and testbench

SHA256_CTRL -- requirements
Module: sha256_ctrl

---
 rtl/sha256_pkg.sv | 24 ++
 rtl/sha256_blk_buf.sv | 57 +++++
 rtl/sha256_ctrl.sv | 141 ++++++++++++++
 tb/tb_sha256_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 block controller.
// The IV, state enum and default geometry live here so the controller and its buffer agree on them.
package sha256_pkg;

  localparam int N_DEF = 32;
  localparam int M_DEF = 16;

  localparam logic [255:0] SHA256_IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_RUN   = 3'd3,
    ST_CHAIN = 3'd4,
    ST_OUT   = 3'd5
  } state_e;

  function automatic logic accepts_words(input state_e s);
    return (s == ST_IDLE) || (s == ST_LOAD);
  endfunction

endpackage

// File: rtl/sha256_blk_buf.sv
// M x N message word buffer with a wrapping write index and a full flag.
// Clear rewinds the index and drops the full flag but keeps the stored words visible to the core.
module sha256_blk_buf
  import sha256_pkg::*;
#(
  parameter  int N  = N_DEF,
  parameter  int M  = M_DEF,
  localparam int IW = (M > 1) ? $clog2(M) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clr_i,
  input  logic                wr_en_i,
  input  logic [N-1:0]        wr_data_i,
  output logic [M-1:0][N-1:0] words_o,
  output logic [IW-1:0]       idx_o,
  output logic                full_o
);

  logic [M-1:0][N-1:0] words_q, words_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                full_q, full_d;
  logic                at_end;

  assign at_end = (idx_q == IW'(M - 1));

  always_comb begin
    words_d = words_q;
    idx_d   = idx_q;
    full_d  = full_q;
    if (clr_i) begin
      idx_d  = '0;
      full_d = 1'b0;
    end else if (wr_en_i && !full_q) begin
      words_d[idx_q] = wr_data_i;
      idx_d          = at_end ? '0 : idx_q + IW'(1);
      full_d         = at_end;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      words_q <= '0;
      idx_q   <= '0;
      full_q  <= 1'b0;
    end else begin
      words_q <= words_d;
      idx_q   <= idx_d;
      full_q  <= full_d;
    end
  end

  assign words_o = words_q;
  assign idx_o   = idx_q;
  assign full_o  = full_q;

endmodule

// File: rtl/sha256_ctrl.sv
// Block sequencer for an external SHA-256 core: gathers M words, runs the core per block,
// chains intermediate hashes and presents the final digest with a valid/ready handshake.
module sha256_ctrl
  import sha256_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int M    = M_DEF,
  parameter int WDOG = 255
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [N-1:0]        word_i,
  input  logic                word_valid_i,
  input  logic                word_last_i,
  output logic                word_ready_o,
  output logic [M-1:0][N-1:0] core_m_o,
  output logic [255:0]        core_h_o,
  output logic                core_rst_o,
  input  logic                core_fl_end_i,
  input  logic [255:0]        core_hash_i,
  output logic [255:0]        digest_o,
  output logic                digest_valid_o,
  input  logic                digest_ready_i,
  output logic                busy_o,
  output logic                err_o
);

  localparam int IW = (M > 1) ? $clog2(M) : 1;
  localparam int WW = $clog2(WDOG + 1);

  state_e          state_q, state_d;
  logic            last_q, last_d;
  logic [255:0]    chain_q, chain_d;
  logic [WW-1:0]   wdog_q, wdog_d;
  logic            err_q, err_d;
  logic            word_ready_q, word_ready_d;

  logic            xfer;
  logic            buf_clr;
  logic            buf_full;
  logic [IW-1:0]   buf_idx;

  assign xfer = word_valid_i & word_ready_q;

  sha256_blk_buf #(
    .N (N),
    .M (M)
  ) u_blk_buf (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (buf_clr),
    .wr_en_i   (xfer),
    .wr_data_i (word_i),
    .words_o   (core_m_o),
    .idx_o     (buf_idx),
    .full_o    (buf_full)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      last_q       <= 1'b0;
      chain_q      <= SHA256_IV;
      wdog_q       <= '0;
      err_q        <= 1'b0;
      word_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      chain_q      <= chain_d;
      wdog_q       <= wdog_d;
      err_q        <= err_d;
      word_ready_q <= word_ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    chain_d = chain_q;
    wdog_d  = wdog_q;
    err_d   = err_q;
    buf_clr = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (xfer) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (xfer && (buf_idx == IW'(M - 1))) begin
          last_d  = word_last_i;
          state_d = ST_START;
        end
      end
      ST_START: begin
        wdog_d  = '0;
        state_d = buf_full ? ST_RUN : ST_LOAD;
      end
      ST_RUN: begin
        if (core_fl_end_i) begin
          state_d = ST_CHAIN;
        end else if (wdog_q == WW'(WDOG - 1)) begin
          // Core never finished: abandon the whole message.
          err_d   = 1'b1;
          chain_d = SHA256_IV;
          last_d  = 1'b0;
          buf_clr = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wdog_d = wdog_q + WW'(1);
        end
      end
      ST_CHAIN: begin
        chain_d = core_hash_i;
        buf_clr = 1'b1;
        state_d = last_q ? ST_OUT : ST_LOAD;
      end
      ST_OUT: begin
        if (digest_ready_i) begin
          chain_d = SHA256_IV;
          last_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Ready is registered from the next state so it stays low through reset and the first edge.
  always_comb begin
    word_ready_d   = accepts_words(state_d);
    busy_o         = (state_q != ST_IDLE);
    core_rst_o     = (state_q != ST_RUN);
    digest_valid_o = (state_q == ST_OUT);
    digest_o       = (state_q == ST_OUT) ? chain_q : '0;
  end

  assign word_ready_o = word_ready_q;
  assign core_h_o     = chain_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_sha256_ctrl.sv
// Directed bench for sha256_ctrl with a behavioural SHA-256 core model attached at the top level.
// Digests are checked against the published SHA-256 test vectors.
module tb_sha256_ctrl;

  localparam int N        = 32;
  localparam int M        = 16;
  localparam int WDOG     = 255;
  localparam int CORE_LAT = 10;

  localparam logic [255:0] IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] ABC_DIG =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] TWO_DIG =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic                clk = 1'b0;
  logic                rst_i;
  logic [N-1:0]        word_i = '0;
  logic                word_valid_i = 1'b0;
  logic                word_last_i = 1'b0;
  logic                word_ready_o;
  logic [M-1:0][N-1:0] core_m_o;
  logic [255:0]        core_h_o;
  logic                core_rst_o;
  logic                core_fl_end_i;
  logic [255:0]        core_hash_i;
  logic [255:0]        digest_o;
  logic                digest_valid_o;
  logic                digest_ready_i = 1'b0;
  logic                busy_o;
  logic                err_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [M-1:0][31:0] blk_abc, blk_two1, blk_two2;

  always #5 clk = ~clk;

  sha256_ctrl #(.N(N), .M(M), .WDOG(WDOG)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .word_i         (word_i),
    .word_valid_i   (word_valid_i),
    .word_last_i    (word_last_i),
    .word_ready_o   (word_ready_o),
    .core_m_o       (core_m_o),
    .core_h_o       (core_h_o),
    .core_rst_o     (core_rst_o),
    .core_fl_end_i  (core_fl_end_i),
    .core_hash_i    (core_hash_i),
    .digest_o       (digest_o),
    .digest_valid_o (digest_valid_o),
    .digest_ready_i (digest_ready_i),
    .busy_o         (busy_o),
    .err_o          (err_o)
  );

  function automatic logic [31:0] ror(input logic [31:0] x, input int s);
    return (x >> s) | (x << (32 - s));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] h, input logic [M-1:0][31:0] m);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
    for (int i = 0; i < 16; i++) w[i] = m[i];
    for (int i = 16; i < 64; i++)
      w[i] = w[i-16] + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3))
           + w[i-7] + (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10));
    {a, b, c, d, e, f, g, hh} = h;
    for (int i = 0; i < 64; i++) begin
      t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
            h[127:96] + e,  h[95:64] + f,   h[63:32] + g,   h[31:0] + hh};
  endfunction

  // Behavioural core: finishes CORE_LAT cycles after release and holds done until reset again.
  logic         model_fl   = 1'b0;
  logic         tb_fl      = 1'b0;
  logic         core_dead  = 1'b0;
  int           core_cnt   = 0;
  logic [255:0] model_hash = '0;

  assign core_fl_end_i = model_fl | tb_fl;
  assign core_hash_i   = model_hash;

  always @(posedge clk) begin
    if (core_rst_o) begin
      core_cnt <= 0;
      model_fl <= 1'b0;
    end else begin
      core_cnt <= core_cnt + 1;
      if (core_cnt == CORE_LAT - 1 && !core_dead) begin
        model_fl   <= 1'b1;
        model_hash <= sha_compress(core_h_o, core_m_o);
      end
    end
  end

  bit mon_en     = 1'b0;
  int ready_viol = 0;
  always @(negedge clk)
    if (mon_en && word_ready_o && (!core_rst_o || digest_valid_o)) ready_viol++;

  task automatic send_words(input logic [M-1:0][31:0] blk, input int first, input int last_i,
                            input logic last_flag, input bit gaps);
    int i = first;
    int guard = 0;
    bit phase = 1'b0;
    while (i <= last_i && guard < 400) begin
      @(negedge clk);
      guard++;
      phase = ~phase;
      if (gaps && !phase) begin
        word_valid_i = 1'b0;
      end else begin
        word_valid_i = 1'b1;
        word_i       = blk[i];
        word_last_i  = (i == M - 1) ? last_flag : ~last_flag;
        if (word_ready_o) i++;
      end
    end
    @(negedge clk);
    word_valid_i = 1'b0;
    word_last_i  = 1'b0;
    n_checks++;
    if (i <= last_i) begin n_fail++; $display("[TB] FAIL send_words: accepted up to %0d, required %0d", i - 1, last_i); end
  endtask

  task automatic wait_digest(input int max, output int cycles, output bit seen);
    cycles = 0;
    while (!digest_valid_o && cycles < max) begin
      @(negedge clk);
      cycles++;
    end
    seen = digest_valid_o;
  endtask

  task automatic handshake();
    @(negedge clk);
    digest_ready_i = 1'b1;
    @(negedge clk);
    digest_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    #1 rst_i = 1'b1;
    #1;
    n_checks++; if (word_ready_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_ready: got %b, required 0", word_ready_o); end
    n_checks++; if (digest_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_dvalid: got %b, required 0", digest_valid_o); end
    n_checks++; if (digest_o !== '0) begin n_fail++; $display("[TB] FAIL rst_digest: got %h, required 0", digest_o); end
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_err: got %b, required 0", err_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_busy: got %b, required 0", busy_o); end
    n_checks++; if (core_rst_o !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_core_rst: got %b, required 1", core_rst_o); end
    n_checks++; if (core_m_o !== '0) begin n_fail++; $display("[TB] FAIL rst_core_m: got %h, required 0", core_m_o); end
    n_checks++; if (core_h_o !== IV) begin n_fail++; $display("[TB] FAIL rst_core_h: got %h, required %h", core_h_o, IV); end
    repeat (2) @(negedge clk);
    n_checks++; if (word_ready_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_ready_clocked: got %b, required 0", word_ready_o); end
    rst_i = 1'b0;
    #1;
    n_checks++; if (word_ready_o !== 1'b0) begin n_fail++; $display("[TB] FAIL ready_before_edge: got %b, required 0", word_ready_o); end
    @(posedge clk);
    #1;
    n_checks++; if (word_ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL ready_after_edge: got %b, required 1", word_ready_o); end
  endtask

  task automatic test_abc();
    int cyc;
    bit seen;
    send_words(blk_abc, 0, M - 1, 1'b1, 1'b0);
    n_checks++; if (core_m_o[0] !== 32'h61626380) begin n_fail++; $display("[TB] FAIL abc_m0: got %h, required 61626380", core_m_o[0]); end
    n_checks++; if (core_m_o[15] !== 32'h00000018) begin n_fail++; $display("[TB] FAIL abc_m15: got %h, required 00000018", core_m_o[15]); end
    n_checks++; if (word_ready_o !== 1'b0) begin n_fail++; $display("[TB] FAIL abc_ready_start: got %b, required 0", word_ready_o); end
    wait_digest(100, cyc, seen);
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("[TB] FAIL abc_dvalid: got %b, required 1", seen); end
    n_checks++; if (cyc != CORE_LAT + 3) begin n_fail++; $display("[TB] FAIL abc_latency: got %0d, required %0d", cyc, CORE_LAT + 3); end
    n_checks++; if (digest_o !== ABC_DIG) begin n_fail++; $display("[TB] FAIL abc_digest: got %h, required %h", digest_o, ABC_DIG); end
    n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("[TB] FAIL abc_busy_out: got %b, required 1", busy_o); end
    handshake();
    n_checks++; if (digest_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL abc_dvalid_drop: got %b, required 0", digest_valid_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL abc_idle: got %b, required 0", busy_o); end
    n_checks++; if (core_h_o !== IV) begin n_fail++; $display("[TB] FAIL abc_iv_reload: got %h, required %h", core_h_o, IV); end
  endtask

  task automatic test_two_block();
    int cyc;
    bit seen;
    int guard = 0;
    logic [255:0] mid;
    mid = sha_compress(IV, blk_two1);
    send_words(blk_two1, 0, M - 1, 1'b0, 1'b0);
    while (!word_ready_o && guard < 100) begin @(negedge clk); guard++; end
    n_checks++; if (word_ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL two_reload_ready: got %b, required 1", word_ready_o); end
    n_checks++; if (digest_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL two_no_early_digest: got %b, required 0", digest_valid_o); end
    n_checks++; if (core_h_o !== mid) begin n_fail++; $display("[TB] FAIL two_chain: got %h, required %h", core_h_o, mid); end
    send_words(blk_two2, 0, M - 1, 1'b1, 1'b0);
    wait_digest(100, cyc, seen);
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("[TB] FAIL two_dvalid: got %b, required 1", seen); end
    n_checks++; if (digest_o !== TWO_DIG) begin n_fail++; $display("[TB] FAIL two_digest: got %h, required %h", digest_o, TWO_DIG); end
    handshake();
  endtask

  task automatic test_throttle();
    int cyc;
    bit seen;
    ready_viol = 0;
    mon_en = 1'b1;
    send_words(blk_abc, 0, M - 1, 1'b1, 1'b1);
    wait_digest(100, cyc, seen);
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("[TB] FAIL thr_dvalid: got %b, required 1", seen); end
    for (int k = 0; k < 20; k++) begin
      n_checks++;
      if (digest_valid_o !== 1'b1 || digest_o !== ABC_DIG) begin
        n_fail++;
        $display("[TB] FAIL thr_hold_%0d: got valid=%b digest=%h, required valid=1 digest=%h", k, digest_valid_o, digest_o, ABC_DIG);
      end
      @(negedge clk);
    end
    handshake();
    mon_en = 1'b0;
    n_checks++; if (ready_viol != 0) begin n_fail++; $display("[TB] FAIL thr_ready_low: got %0d violations, required 0", ready_viol); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit seen;
    int guard = 0;
    int stray = 0;
    send_words(blk_two1, 0, M - 1, 1'b0, 1'b0);
    while (core_rst_o && guard < 40) begin @(negedge clk); guard++; end
    n_checks++; if (core_rst_o !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_reach_run: got core_rst=%b, required 0", core_rst_o); end
    #2 rst_i = 1'b1;
    #1;
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_busy: got %b, required 0", busy_o); end
    n_checks++; if (core_rst_o !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_core_rst: got %b, required 1", core_rst_o); end
    n_checks++; if (core_m_o !== '0) begin n_fail++; $display("[TB] FAIL mid_core_m: got %h, required 0", core_m_o); end
    n_checks++; if (core_h_o !== IV) begin n_fail++; $display("[TB] FAIL mid_core_h: got %h, required %h", core_h_o, IV); end
    @(negedge clk);
    rst_i = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (digest_valid_o) stray++;
    end
    n_checks++; if (stray != 0) begin n_fail++; $display("[TB] FAIL mid_stray_digest: got %0d, required 0", stray); end
    send_words(blk_abc, 0, M - 1, 1'b1, 1'b0);
    wait_digest(100, cyc, seen);
    n_checks++; if (digest_o !== ABC_DIG) begin n_fail++; $display("[TB] FAIL mid_abc_digest: got %h, required %h", digest_o, ABC_DIG); end
    handshake();
  endtask

  task automatic test_fl_in_load();
    int cyc;
    bit seen;
    send_words(blk_abc, 0, 7, 1'b1, 1'b0);
    tb_fl = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (word_ready_o !== 1'b1 || busy_o !== 1'b1 || core_rst_o !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL fl_load_ignored: got ready=%b busy=%b core_rst=%b, required 1 1 1", word_ready_o, busy_o, core_rst_o);
    end
    tb_fl = 1'b0;
    send_words(blk_abc, 8, M - 1, 1'b1, 1'b0);
    wait_digest(100, cyc, seen);
    n_checks++; if (cyc != CORE_LAT + 3) begin n_fail++; $display("[TB] FAIL fl_latency: got %0d, required %0d", cyc, CORE_LAT + 3); end
    n_checks++; if (digest_o !== ABC_DIG) begin n_fail++; $display("[TB] FAIL fl_digest: got %h, required %h", digest_o, ABC_DIG); end
    handshake();
  endtask

  task automatic test_watchdog();
    int cyc;
    bit seen;
    int run = 0;
    int dv = 0;
    int guard = 0;
    core_dead = 1'b1;
    send_words(blk_abc, 0, M - 1, 1'b1, 1'b0);
    while (!err_o && guard < WDOG + 50) begin
      @(negedge clk);
      guard++;
      if (!core_rst_o) run++;
      if (digest_valid_o) dv++;
    end
    n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("[TB] FAIL wd_err: got %b, required 1", err_o); end
    n_checks++; if (run != WDOG) begin n_fail++; $display("[TB] FAIL wd_run_cycles: got %0d, required %0d", run, WDOG); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL wd_idle: got busy=%b, required 0", busy_o); end
    n_checks++; if (dv != 0) begin n_fail++; $display("[TB] FAIL wd_no_digest: got %0d, required 0", dv); end
    n_checks++; if (core_h_o !== IV) begin n_fail++; $display("[TB] FAIL wd_iv: got %h, required %h", core_h_o, IV); end
    core_dead = 1'b0;
    send_words(blk_abc, 0, M - 1, 1'b1, 1'b0);
    wait_digest(100, cyc, seen);
    n_checks++; if (digest_o !== ABC_DIG) begin n_fail++; $display("[TB] FAIL wd_recover_digest: got %h, required %h", digest_o, ABC_DIG); end
    n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("[TB] FAIL wd_err_sticky: got %b, required 1", err_o); end
    handshake();
    #2 rst_i = 1'b1;
    #1;
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("[TB] FAIL wd_err_clear: got %b, required 0", err_o); end
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  initial begin
    blk_abc      = '0;
    blk_abc[0]   = 32'h61626380;
    blk_abc[15]  = 32'h00000018;
    blk_two1     = '0;
    blk_two1[0]  = 32'h61626364; blk_two1[1]  = 32'h62636465; blk_two1[2]  = 32'h63646566;
    blk_two1[3]  = 32'h64656667; blk_two1[4]  = 32'h65666768; blk_two1[5]  = 32'h66676869;
    blk_two1[6]  = 32'h6768696a; blk_two1[7]  = 32'h68696a6b; blk_two1[8]  = 32'h696a6b6c;
    blk_two1[9]  = 32'h6a6b6c6d; blk_two1[10] = 32'h6b6c6d6e; blk_two1[11] = 32'h6c6d6e6f;
    blk_two1[12] = 32'h6d6e6f70; blk_two1[13] = 32'h6e6f7071; blk_two1[14] = 32'h80000000;
    blk_two2     = '0;
    blk_two2[15] = 32'h000001c0;

    test_reset();
    test_abc();
    test_two_block();
    test_throttle();
    test_reset_mid();
    test_fl_in_load();
    test_watchdog();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation time limit reached, required completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
